// File: rtl/eth_mac_stats_pkg.sv
// ======================================================================
// eth_mac_stats_pkg: event index map and helpers for the MAC stats block
// Rev 1.0
// ======================================================================
`default_nettype none

package eth_mac_stats_pkg;

   localparam int EV_TX_UNDERFLOW     = 0;
   localparam int EV_TX_FIFO_OVERFLOW = 1;
   localparam int EV_TX_FIFO_BAD      = 2;
   localparam int EV_TX_FIFO_GOOD     = 3;
   localparam int EV_RX_BAD_FRAME     = 4;
   localparam int EV_RX_BAD_FCS       = 5;
   localparam int EV_RX_FIFO_OVERFLOW = 6;
   localparam int EV_RX_FIFO_BAD      = 7;
   localparam int EV_RX_FIFO_GOOD     = 8;
   localparam int EV_SPARE            = 9;

   localparam int DEFAULT_EVENT_COUNT = 10;

   // A single counter still needs a one-bit address so the port exists.
   function automatic int addr_width_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/eth_mac_stats_counter.sv
// ======================================================================
// eth_mac_stats_counter: one live event counter, its snapshot shadow and
// a sticky overflow flag.                                      Rev 1.0
// ======================================================================
`default_nettype none

module eth_mac_stats_counter
   import eth_mac_stats_pkg::*;
#(
   parameter int COUNT_WIDTH       = 32,
   parameter bit SATURATE          = 1'b1,
   parameter bit CLEAR_ON_SNAPSHOT = 1'b1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inc,
   input  logic                   snapshot,
   input  logic                   clear_all,
   output logic [COUNT_WIDTH-1:0] shadow,
   output logic                   sat_flag
);

   logic [COUNT_WIDTH-1:0] live;
   logic                   at_max;

   assign at_max = &live;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live     <= '0;
         shadow   <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (snapshot) begin
            shadow <= live;
         end

         // Clear wins over everything, including a same-cycle event.
         if (clear_all) begin
            live     <= '0;
            sat_flag <= 1'b0;
         end else if (snapshot && CLEAR_ON_SNAPSHOT) begin
            live <= {{(COUNT_WIDTH-1){1'b0}}, inc};
         end else if (inc) begin
            if (at_max) begin
               sat_flag <= 1'b1;
               live     <= SATURATE ? live : '0;
            end else begin
               live <= live + COUNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/eth_mac_stats.sv
// ======================================================================
// eth_mac_stats: N event counters with atomic snapshot and a valid/ready
// read port over the shadow registers.                         Rev 1.0
// ======================================================================
`default_nettype none

module eth_mac_stats
   import eth_mac_stats_pkg::*;
#(
   parameter int EVENT_COUNT       = DEFAULT_EVENT_COUNT,
   parameter int COUNT_WIDTH       = 32,
   parameter bit SATURATE          = 1'b1,
   parameter bit CLEAR_ON_SNAPSHOT = 1'b1,
   parameter int ADDR_WIDTH        = addr_width_for(EVENT_COUNT)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [EVENT_COUNT-1:0] event_in,
   input  logic                   snapshot,
   input  logic                   clear_all,
   input  logic [ADDR_WIDTH-1:0]  s_rd_addr,
   input  logic                   s_rd_valid,
   output logic                   s_rd_ready,
   output logic [COUNT_WIDTH-1:0] m_rd_data,
   output logic                   m_rd_error,
   output logic                   m_rd_valid,
   input  logic                   m_rd_ready,
   output logic [EVENT_COUNT-1:0] sat_flag,
   output logic                   snapshot_busy
);

   localparam int                ADDR_SPACE = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] NUM_EVENTS = (ADDR_WIDTH+1)'(EVENT_COUNT);

   logic [COUNT_WIDTH-1:0] shadow_val [EVENT_COUNT];
   logic [COUNT_WIDTH-1:0] rd_table   [ADDR_SPACE];
   logic                   addr_ok;
   logic                   rd_accept;

   generate
      for (genvar i = 0; i < EVENT_COUNT; i++) begin : g_counter
         eth_mac_stats_counter #(
            .COUNT_WIDTH       (COUNT_WIDTH),
            .SATURATE          (SATURATE),
            .CLEAR_ON_SNAPSHOT (CLEAR_ON_SNAPSHOT)
         ) u_counter (
            .clk       (clk),
            .rst       (rst),
            .inc       (event_in[i]),
            .snapshot  (snapshot),
            .clear_all (clear_all),
            .shadow    (shadow_val[i]),
            .sat_flag  (sat_flag[i])
         );
      end

      // Pad the mux to the full address space so any address indexes safely.
      for (genvar a = 0; a < ADDR_SPACE; a++) begin : g_rd_table
         if (a < EVENT_COUNT) begin : g_used
            assign rd_table[a] = shadow_val[a];
         end else begin : g_unused
            assign rd_table[a] = '0;
         end
      end
   endgenerate

   assign addr_ok    = ({1'b0, s_rd_addr} < NUM_EVENTS);
   assign s_rd_ready = !m_rd_valid || m_rd_ready;
   assign rd_accept  = s_rd_valid && s_rd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rd_valid    <= 1'b0;
         m_rd_data     <= '0;
         m_rd_error    <= 1'b0;
         snapshot_busy <= 1'b0;
      end else begin
         snapshot_busy <= snapshot;
         if (rd_accept) begin
            m_rd_valid <= 1'b1;
            m_rd_data  <= addr_ok ? rd_table[s_rd_addr] : '0;
            m_rd_error <= !addr_ok;
         end else if (m_rd_ready) begin
            m_rd_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
